// File: rtl/bus_timer_pkg.sv
// rtl/bus_timer_pkg.sv - register map, CTRL/STATUS bit positions for bus_timer
package bus_timer_pkg;

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_COUNT   = 2'd1,
        REG_COMPARE = 2'd2,
        REG_STATUS  = 2'd3
    } reg_offset_e;

    localparam int CTRL_EN           = 0;
    localparam int CTRL_CLR_ON_MATCH = 1;
    localparam int CTRL_IRQ_EN       = 2;
    localparam int CTRL_ONE_SHOT     = 3;
    localparam int PRESCALE_LSB      = 8;
    localparam int PRESCALE_W        = 8;

    localparam int STATUS_MATCH = 0;
    localparam int STATUS_OVF   = 1;

    localparam logic [15:0] CTRL_RW_MASK = 16'hFF0F;

endpackage

// File: rtl/bus_timer_prescaler.sv
// rtl/bus_timer_prescaler.sv - 8-bit prescaler producing a tick every prescale+1 enabled cycles
module bus_timer_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] prescale,
    output logic       tick
);

    logic [7:0] presc_cnt;

    assign tick = en && (presc_cnt == prescale);

    // The tick of the current cycle still counts when clr is asserted; only the phase restarts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_cnt <= '0;
        end else if (clr || !en || tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// rtl/bus_timer.sv - memory-mapped timer on the shared CPU bus; PWM output built when BUS_TIMER_PWM_EN is defined
module bus_timer #(
    parameter int                    ADDR_WIDTH    = 20,
    parameter int                    DATA_WIDTH    = 16,
    parameter logic [ADDR_WIDTH-1:0] START_ADDRESS = 20'h00400
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    input  logic                  read,
    input  logic                  write,
    output logic                  irq,
    output logic                  pwm_out
);

    import bus_timer_pkg::*;

    localparam logic [DATA_WIDTH-1:0] CTRL_MASK = DATA_WIDTH'(CTRL_RW_MASK);

    logic [DATA_WIDTH-1:0] ctrl_q;
    logic [DATA_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0] compare_q;
    logic [1:0]            status_q;
    logic [DATA_WIDTH-1:0] rdata;

    logic        hit;
    logic        rd_hit;
    logic        wr_hit;
    reg_offset_e offset;
    logic        wr_ctrl;
    logic        wr_count;
    logic        wr_compare;
    logic        wr_status;
    logic        tick;
    logic        count_match;
    logic        set_match;
    logic        set_ovf;

    assign hit    = (bus_addr[ADDR_WIDTH-1:2] == START_ADDRESS[ADDR_WIDTH-1:2]);
    assign offset = reg_offset_e'(bus_addr[1:0]);
    assign rd_hit = read && !write && hit;
    assign wr_hit = write && hit;

    assign wr_ctrl    = wr_hit && (offset == REG_CTRL);
    assign wr_count   = wr_hit && (offset == REG_COUNT);
    assign wr_compare = wr_hit && (offset == REG_COMPARE);
    assign wr_status  = wr_hit && (offset == REG_STATUS);

    bus_timer_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (ctrl_q[CTRL_EN]),
        .clr      (wr_ctrl),
        .prescale (ctrl_q[PRESCALE_LSB +: PRESCALE_W]),
        .tick     (tick)
    );

    // A CPU write to COUNT pre-empts the tick entirely, including its flags.
    assign count_match = (count_q == compare_q);
    assign set_match   = tick && !wr_count && count_match;
    assign set_ovf     = tick && !wr_count && !count_match && (&count_q);

    always_comb begin
        rdata = '0;
        case (offset)
            REG_CTRL:    rdata = ctrl_q;
            REG_COUNT:   rdata = count_q;
            REG_COMPARE: rdata = compare_q;
            REG_STATUS:  rdata = DATA_WIDTH'(status_q);
            default:     rdata = '0;
        endcase
    end

    assign bus_data = rd_hit ? rdata : 'z;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q    <= '0;
            count_q   <= '0;
            compare_q <= '0;
            status_q  <= '0;
            irq       <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_q <= bus_data & CTRL_MASK;
            end else if (set_match && ctrl_q[CTRL_ONE_SHOT]) begin
                ctrl_q[CTRL_EN] <= 1'b0;
            end

            // All-ones + 1 wraps to zero, which is the overflow case.
            if (wr_count) begin
                count_q <= bus_data;
            end else if (tick) begin
                if (count_match && ctrl_q[CTRL_CLR_ON_MATCH]) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_q + DATA_WIDTH'(1);
                end
            end

            if (wr_compare) begin
                compare_q <= bus_data;
            end

            status_q <= (status_q & ~(wr_status ? bus_data[1:0] : 2'b00))
                      | {set_ovf, set_match};

            irq <= ctrl_q[CTRL_IRQ_EN] && (|status_q);
        end
    end

`ifdef BUS_TIMER_PWM_EN
    logic pwm_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= ctrl_q[CTRL_EN] && (count_q < compare_q);
        end
    end

    assign pwm_out = pwm_q;
`else
    assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_bus_timer.sv
// tb/tb_bus_timer.sv - randomized self-checking bench for bus_timer against a behavioural model
module tb_bus_timer;

    localparam int              AW    = 20;
    localparam int              DW    = 16;
    localparam logic [AW-1:0]   BASE  = 20'h00400;
    localparam logic [DW-1:0]   FLOAT = 16'hFFFF;

`ifdef BUS_TIMER_PWM_EN
    localparam bit PWM_BUILT = 1'b1;
`else
    localparam bit PWM_BUILT = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic [AW-1:0] bus_addr  = BASE;
    logic          read      = 1'b0;
    logic          write     = 1'b0;
    logic          tb_drv_en = 1'b0;
    logic [DW-1:0] tb_wdata  = '0;
    tri1  [DW-1:0] bus_data;
    logic          irq;
    logic          pwm_out;

    assign bus_data = tb_drv_en ? tb_wdata : 'z;

    always #5 clk = ~clk;

    bus_timer #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .START_ADDRESS (BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus_addr (bus_addr),
        .bus_data (bus_data),
        .read     (read),
        .write    (write),
        .irq      (irq),
        .pwm_out  (pwm_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: architectural state after each rising edge.
    logic [15:0] m_ctrl, m_count, m_cmp;
    logic [1:0]  m_status;
    int          m_presc;
    bit          m_irq, m_pwm;

    task automatic m_reset();
        m_ctrl = 0; m_count = 0; m_cmp = 0; m_status = 0;
        m_presc = 0; m_irq = 0; m_pwm = 0;
    endtask

    function automatic logic [15:0] m_read(input logic [1:0] off);
        case (off)
            2'd0:    return m_ctrl;
            2'd1:    return m_count;
            2'd2:    return m_cmp;
            default: return {14'd0, m_status};
        endcase
    endfunction

    task automatic m_step(input bit wr, input logic [AW-1:0] a, input logic [15:0] d);
        bit          hit;
        int          off;
        bit          w;
        bit          en;
        bit          tick;
        logic [15:0] n_ctrl, n_count, n_cmp;
        logic [1:0]  n_status, sets;
        hit   = (a >> 2) == (BASE >> 2);
        off   = int'(a & 3);
        w     = wr && hit;
        en    = m_ctrl[0];
        tick  = en && (m_presc == int'(m_ctrl >> 8));
        n_ctrl = m_ctrl; n_count = m_count; n_cmp = m_cmp; n_status = m_status; sets = 2'b00;

        m_irq = m_ctrl[2] && (m_status != 0);
        m_pwm = PWM_BUILT && en && (m_count < m_cmp);
        m_presc = ((w && off == 0) || !en || tick) ? 0 : m_presc + 1;

        if (tick && !(w && off == 1)) begin
            if (m_count == m_cmp) begin
                sets[0] = 1'b1;
                n_count = m_ctrl[1] ? 16'd0 : 16'((int'(m_count) + 1) % 65536);
                if (m_ctrl[3]) n_ctrl[0] = 1'b0;
            end else if (m_count == 16'hFFFF) begin
                n_count = 0;
                sets[1] = 1'b1;
            end else begin
                n_count = m_count + 16'd1;
            end
        end
        if (w) begin
            case (off)
                0:       n_ctrl = d & 16'hFF0F;
                1:       n_count = d;
                2:       n_cmp = d;
                default: n_status = m_status & ~d[1:0];
            endcase
        end
        m_ctrl = n_ctrl; m_count = n_count; m_cmp = n_cmp; m_status = n_status | sets;
    endtask

    // One bus cycle: inputs set after a rising edge, outputs checked at the falling edge.
    task automatic cycle(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [15:0] d,
                         output logic [15:0] obs);
        logic [15:0] exp;
        bit          hit;
        read = rd; write = wr; bus_addr = a; tb_wdata = d; tb_drv_en = wr;
        @(negedge clk);
        hit = (a >> 2) == (BASE >> 2);
        exp = wr ? d : ((rd && hit) ? m_read(a[1:0]) : FLOAT);
        obs = bus_data;
        check("bus_data", obs, exp);
        check("irq", {15'd0, irq}, {15'd0, m_irq});
        check("pwm_out", {15'd0, pwm_out}, {15'd0, m_pwm});
        @(posedge clk);
        m_step(wr, a, d);
        #1;
        read = 0; write = 0; tb_drv_en = 0;
    endtask

    task automatic wr_reg(input logic [1:0] off, input logic [15:0] d);
        logic [15:0] obs;
        cycle(1'b0, 1'b1, BASE + AW'(off), d, obs);
    endtask

    task automatic rd_reg(input logic [1:0] off, output logic [15:0] obs);
        cycle(1'b1, 1'b0, BASE + AW'(off), 16'd0, obs);
    endtask

    task automatic idle(input int n);
        logic [15:0] obs;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, BASE, 16'd0, obs);
    endtask

    task automatic do_reset();
        read = 1; write = 0; tb_drv_en = 0; bus_addr = BASE + 20'd1;
        @(negedge clk);
        #1 reset = 0;
        #1;
        check("rst_irq", {15'd0, irq}, 16'd0);
        check("rst_pwm", {15'd0, pwm_out}, 16'd0);
        check("rst_count_rd", bus_data, 16'd0);
        m_reset();
        @(posedge clk);
        #1 reset = 1; read = 0;
    endtask

    function automatic logic [15:0] rand_data(input logic [1:0] off);
        case (off)
            2'd0: return {6'd0, 2'($urandom_range(0, 3)), 4'($urandom), 3'($urandom), 1'($urandom_range(0, 3) != 0)};
            2'd1: begin
                case ($urandom_range(0, 2))
                    0:       return 16'($urandom_range(0, 15));
                    1:       return 16'hFFF8 + 16'($urandom_range(0, 7));
                    default: return 16'($urandom);
                endcase
            end
            2'd2:    return ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
            default: return 16'($urandom);
        endcase
    endfunction

    logic [15:0] obs;
    logic [15:0] exp_seq [8];

    initial begin
        m_reset();
        #1 reset = 0;
        #1;
        check("rst_irq0", {15'd0, irq}, 16'd0);
        check("rst_pwm0", {15'd0, pwm_out}, 16'd0);
        @(posedge clk);
        #1 reset = 1;

        for (int i = 0; i < 4; i++) begin
            rd_reg(2'(i), obs);
            check("reset_reg", obs, 16'h0000);
        end
        cycle(1'b0, 1'b0, BASE, 16'd0, obs);
        cycle(1'b1, 1'b0, 20'h00404, 16'd0, obs);
        check("miss_float", obs, FLOAT);

        // Match with clear-on-match, irq, W1C
        wr_reg(2'd2, 16'd5);
        wr_reg(2'd0, 16'h0007);
        exp_seq = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0, 16'd1};
        for (int k = 0; k < 8; k++) begin
            rd_reg(2'd1, obs);
            check("match_seq", obs, exp_seq[k]);
        end
        check("irq_after_match", {15'd0, irq}, 16'd1);
        wr_reg(2'd3, 16'h0001);
        idle(1);
        check("irq_cleared", {15'd0, irq}, 16'd0);
        idle(8);
        wr_reg(2'd0, 16'h0000);

        // Prescale 3
        wr_reg(2'd1, 16'd0);
        wr_reg(2'd3, 16'h0003);
        wr_reg(2'd0, 16'h0301);
        for (int k = 0; k < 12; k++) begin
            rd_reg(2'd1, obs);
            check("presc_seq", obs, 16'(k / 4));
        end
        idle(2);
        wr_reg(2'd0, 16'h0301);
        for (int k = 0; k < 9; k++) rd_reg(2'd1, obs);

        // Overflow then match
        wr_reg(2'd0, 16'h0000);
        wr_reg(2'd1, 16'hFFFE);
        wr_reg(2'd2, 16'h0000);
        wr_reg(2'd3, 16'h0003);
        wr_reg(2'd0, 16'h0001);
        rd_reg(2'd1, obs); check("ovf_cnt0", obs, 16'hFFFE);
        rd_reg(2'd1, obs); check("ovf_cnt1", obs, 16'hFFFF);
        rd_reg(2'd3, obs); check("ovf_flag", obs, 16'h0002);
        rd_reg(2'd3, obs); check("ovf_then_match", obs, 16'h0003);

        // One-shot
        wr_reg(2'd0, 16'h0000);
        wr_reg(2'd3, 16'h0003);
        wr_reg(2'd1, 16'd0);
        wr_reg(2'd2, 16'd3);
        wr_reg(2'd0, 16'h000B);
        idle(7);
        rd_reg(2'd0, obs); check("oneshot_ctrl", obs, 16'h000A);
        rd_reg(2'd1, obs); check("oneshot_count", obs, 16'h0000);
        rd_reg(2'd3, obs); check("oneshot_status", obs, 16'h0001);

        // COUNT write collides with a matching tick
        wr_reg(2'd3, 16'h0003);
        wr_reg(2'd1, 16'h0010);
        wr_reg(2'd2, 16'h0010);
        wr_reg(2'd0, 16'h0001);
        wr_reg(2'd1, 16'd7);
        rd_reg(2'd1, obs); check("wr_beats_tick", obs, 16'd7);
        rd_reg(2'd3, obs); check("no_flag_on_wr", obs, 16'h0000);

        // PWM pattern then reset mid-pattern
        wr_reg(2'd0, 16'h0000);
        wr_reg(2'd3, 16'h0003);
        wr_reg(2'd1, 16'd0);
        wr_reg(2'd2, 16'd2);
        wr_reg(2'd0, 16'h0003);
        idle(8);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rd_reg(2'(i), obs);
            check("post_reset_reg", obs, 16'h0000);
        end

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            int            r;
            logic [1:0]    off;
            logic [AW-1:0] a;
            r   = int'($urandom_range(0, 99));
            off = 2'($urandom_range(0, 3));
            a   = BASE + AW'(off);
            if ($urandom_range(0, 9) == 0) a = AW'($urandom);
            if (i == 400) do_reset();
            if (r < 40)      cycle(1'b0, 1'b0, a, 16'd0, obs);
            else if (r < 72) cycle(1'b1, 1'b0, a, 16'd0, obs);
            else if (r < 76) cycle(1'b1, 1'b1, a, rand_data(off), obs);
            else             cycle(1'b0, 1'b1, a, rand_data(off), obs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
